noc_output_ctrl: RTL and testbench
==================================

Name: noc_output_ctrl

Overview:
Output-side merge stage of a tree NoC router port, the counterpart of the input control demux. It accepts packets from two upstream routing paths (e.g. child and sibling directions) and merges them with round-robin arbitration. Each granted packet goes out on one channel as the sending end of a 4-phase bundled-data handshake. Clocked logic; the output ack comes from the asynchronous CSP side and is synchronized internally.

Parameters:
WIDTH_packet, 14, packet width in bits; passed through unmodified
WIDTH_addr, 3, destination field width, packet[WIDTH_packet-1 -: WIDTH_addr]; used only by assertions/debug
SYNC_STAGES, 2, flops in the out_ack synchronizer (>=2)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in0_data  in  WIDTH_packet  packet from path 0
in0_valid  in  1  path 0 packet valid
in0_ready  out  1  path 0 buffer empty; transfer when valid&&ready at a rising edge
in1_data  in  WIDTH_packet  packet from path 1
in1_valid  in  1  path 1 packet valid
in1_ready  out  1  path 1 buffer empty
out_data  out  WIDTH_packet  bundled data, stable whenever out_req=1 or ack pending
out_req  out  1  4-phase request
out_ack  in  1  4-phase acknowledge, asynchronous to clk
last_grant  out  1  index of the most recently granted input (debug/verification)

Behaviour:
- Reset (rst_n=0, async): in0_ready=in1_ready=1 (buffers empty), out_req=0, out_data=0, last_grant=1 (so in0 wins the first tie), FSM=IDLE, synchronizer flops=0. Buffered packets and any in-flight handshake are discarded; out_req drops immediately.
- Input buffers: one entry per input. inX_ready = ~fullX (registered). On valid&&ready the data is captured and fullX=1 next cycle. No accept while full, so capture and grant never collide on the same buffer.
- ack_s = out_ack after SYNC_STAGES flops.
- FSM IDLE: if ack_s=0 and at least one buffer is full, grant. Only one full: grant it. Both full: grant ~last_grant. On grant edge: out_data<=buf, fullX<=0 (ready high next cycle), last_grant<=X, out_req<=1, go to REQ. If ack_s=1 in IDLE (stale or violating ack), no grant until it returns to 0.
- REQ: hold out_req=1 and out_data. When ack_s=1: out_req<=0, go to RELEASE.
- RELEASE: hold out_data. When ack_s=0, go to IDLE. The next grant comes at the earliest on the following edge.
- Latency: input accepted at edge N -> out_req rises at edge N+1 (FSM idle, ack_s=0). Minimum handshake is 1 (grant) + SYNC_STAGES + SYNC_STAGES + 1 cycles after ack toggles.
- out_data changes only on a grant edge, never while out_req=1 or during RELEASE.
- Fairness: with both inputs continuously valid, grants strictly alternate. No input waits more than one other packet.
- Packet bits are not inspected or altered.
- Assertion: out_ack must not rise while out_req=0 (flag violation, behaviour as above).

Test Plan:
- Reset then in0 sends 14'h2A5; bucket acks 3 cycles after req -> out_req rises 1 cycle after accept, out_data=14'h2A5 stable until ack falls, in0_ready back high the cycle after grant.
- in0 and in1 valid on the same edge with 14'h0011/14'h1022 -> in0 delivered first (last_grant reset 1), then in1. last_grant goes 0 then 1.
- Both inputs streaming 6 packets each -> output order alternates strictly 0,1,0,1...; no loss or duplication, all 12 packets delivered.
- Bucket holds ack high for 20 cycles -> out_req low after ack_s rises, no new grant until ack_s=0, out_data unchanged throughout, in1 packet waits in its buffer with in1_ready=0.
- rst_n pulsed low while out_req=1 and both buffers full -> out_req=0 and both readies=1 immediately. After release, ack low: no spurious transfer. The first new packet goes out normally.
- out_ack forced high while IDLE with in0 packet buffered -> no grant while high, assertion fires. Packet goes out within 2 cycles after ack_s returns to 0.

Source files
------------

// File: rtl/noc_output_ctrl.sv
// Output merge stage of a tree NoC router port: two single-entry input buffers,
// round-robin arbitration, and the sending side of a 4-phase bundled-data handshake.
module noc_output_ctrl #(
    parameter int WIDTH_packet = 14,
    parameter int WIDTH_addr   = 3,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH_packet-1:0] in0_data,
    input  logic                    in0_valid,
    output logic                    in0_ready,
    input  logic [WIDTH_packet-1:0] in1_data,
    input  logic                    in1_valid,
    output logic                    in1_ready,
    output logic [WIDTH_packet-1:0] out_data,
    output logic                    out_req,
    input  logic                    out_ack,
    output logic                    last_grant
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic                    full0;
    logic                    full1;
    logic [WIDTH_packet-1:0] buf0;
    logic [WIDTH_packet-1:0] buf1;
    logic                    accept0;
    logic                    accept1;

    logic [SYNC_STAGES-1:0]  ack_sync;
    logic                    ack_s;
    logic                    ack_rise;

    logic                    do_grant;
    logic                    grant_idx;
    logic [WIDTH_packet-1:0] grant_data;
    logic                    out_req_next;

    logic                    ack_violation;
    logic [WIDTH_addr-1:0]   out_dest;
    logic [WIDTH_addr-1:0]   dest_hold;

    assign in0_ready = ~full0;
    assign in1_ready = ~full1;
    assign accept0   = in0_valid & ~full0;
    assign accept1   = in1_valid & ~full1;

    assign ack_s     = ack_sync[SYNC_STAGES-1];
    assign ack_rise  = ack_sync[0] & ~ack_sync[1];
    assign out_dest  = out_data[WIDTH_packet-1 -: WIDTH_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], out_ack};
        end
    end

    // A full buffer never accepts, so capture and grant cannot hit the same entry in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full0 <= 1'b0;
            full1 <= 1'b0;
            buf0  <= '0;
            buf1  <= '0;
        end else begin
            if (accept0) begin
                full0 <= 1'b1;
                buf0  <= in0_data;
            end else if (do_grant && !grant_idx) begin
                full0 <= 1'b0;
            end
            if (accept1) begin
                full1 <= 1'b1;
                buf1  <= in1_data;
            end else if (do_grant && grant_idx) begin
                full1 <= 1'b0;
            end
        end
    end

    // Grants only from IDLE with the ack low; a tie goes to the input not served last.
    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        grant_idx  = ~last_grant;
        case (state)
            IDLE: begin
                if (!ack_s && (full0 || full1)) begin
                    do_grant   = 1'b1;
                    grant_idx  = (full0 && full1) ? ~last_grant : full1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (!ack_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        grant_data   = grant_idx ? buf1 : buf0;
        out_req_next = (state_next == REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_req    <= 1'b0;
            out_data   <= '0;
            last_grant <= 1'b1;
            dest_hold  <= '0;
        end else begin
            state   <= state_next;
            out_req <= out_req_next;
            if (do_grant) begin
                out_data   <= grant_data;
                last_grant <= grant_idx;
                dest_hold  <= grant_data[WIDTH_packet-1 -: WIDTH_addr];
            end
        end
    end

    // Sticky flag: the receiver raised ack without an outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_violation <= 1'b0;
        end else if (ack_rise && !out_req) begin
            ack_violation <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (rst_n && state != IDLE) begin
            assert (out_dest == dest_hold);
        end
        if (rst_n) begin
            assert (out_req == (state == REQ));
        end
        if (rst_n && do_grant) begin
            assert (!ack_s && (grant_idx ? full1 : full0));
        end
    end

    cover property (@(posedge clk) disable iff (!rst_n) ack_violation);

endmodule

// File: tb/tb_noc_output_ctrl.sv
// Self-checking bench for noc_output_ctrl: table-driven vectors, a receiver model
// that completes the 4-phase handshake, and a scoreboard of expected deliveries.
module tb_noc_output_ctrl;

    localparam int W = 14;

    typedef struct {
        logic         v0;
        logic [W-1:0] d0;
        logic         v1;
        logic [W-1:0] d1;
        logic         first;
    } vec_t;

    typedef struct {
        logic [W-1:0] data;
        logic         src;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] in0_data;
    logic         in0_valid;
    logic         in0_ready;
    logic [W-1:0] in1_data;
    logic         in1_valid;
    logic         in1_ready;
    logic [W-1:0] out_data;
    logic         out_req;
    logic         out_ack;
    logic         last_grant;

    logic         bucket_ack;
    logic         force_ack;
    logic         auto_ack;
    int           ack_delay;
    int           ack_hold;
    logic         model_last;

    exp_t         sb[$];
    vec_t         vecs[8];
    int           total;
    int           bad;

    assign out_ack = bucket_ack | force_ack;

    noc_output_ctrl #(
        .WIDTH_packet(W),
        .WIDTH_addr  (3),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_data  (in0_data),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in1_data  (in1_data),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .out_data  (out_data),
        .out_req   (out_req),
        .out_ack   (out_ack),
        .last_grant(last_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic pushExp(input logic [W-1:0] d, input logic s);
        exp_t e;
        e.data = d;
        e.src  = s;
        sb.push_back(e);
    endtask

    // Offers the given packets starting at a falling edge; each valid drops after its accept edge.
    task automatic applyStimulus(input logic v0, input logic [W-1:0] d0,
                                 input logic v1, input logic [W-1:0] d1);
        logic p0, p1, a0, a1;
        int   n;
        p0 = v0;
        p1 = v1;
        in0_valid = p0;
        in0_data  = d0;
        in1_valid = p1;
        in1_data  = d1;
        n = 0;
        while ((p0 || p1) && n < 200) begin
            a0 = p0 && in0_ready;
            a1 = p1 && in1_ready;
            @(posedge clk);
            @(negedge clk);
            if (a0) begin
                p0 = 1'b0;
                in0_valid = 1'b0;
            end
            if (a1) begin
                p1 = 1'b0;
                in1_valid = 1'b0;
            end
            n++;
        end
        checkOutput("accept", {30'd0, p0, p1}, 32'd0);
        in0_valid = 1'b0;
        in1_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_req || out_ack) && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        checkOutput("drain_busy", {31'd0, (sb.size() != 0 || out_req)}, 32'd0);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_last = 1'b1;
        @(negedge clk);
    endtask

    // Receiver: on a new request checks the head of the scoreboard, acks after ack_delay,
    // holds ack ack_hold cycles past the request drop, and watches out_data stay put.
    initial begin
        exp_t e;
        logic stable_ok;
        int   n;
        bucket_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (auto_ack && out_req && !bucket_ack) begin
                checkOutput("sb_has_entry", {31'd0, (sb.size() > 0)}, 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    model_last = e.src;
                    checkOutput("out_data", {18'd0, out_data}, {18'd0, e.data});
                    checkOutput("last_grant", {31'd0, last_grant}, {31'd0, e.src});
                    stable_ok = 1'b1;
                    for (int i = 0; i < ack_delay; i++) begin
                        @(negedge clk);
                        if (out_data !== e.data || !out_req) stable_ok = 1'b0;
                    end
                    bucket_ack = 1'b1;
                    n = 0;
                    while (out_req && n < 100) begin
                        @(negedge clk);
                        if (out_data !== e.data) stable_ok = 1'b0;
                        n++;
                    end
                    checkOutput("req_release", {31'd0, out_req}, 32'd0);
                    for (int i = 0; i < ack_hold; i++) begin
                        @(negedge clk);
                        if (out_data !== e.data || out_req) stable_ok = 1'b0;
                    end
                    bucket_ack = 1'b0;
                    checkOutput("data_stable", {31'd0, stable_ok}, 32'd1);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int   n;
        logic ok;
        logic g;

        vecs[0] = '{1'b1, 14'h0ABC, 1'b0, 14'h0000, 1'b0};
        vecs[1] = '{1'b0, 14'h0000, 1'b1, 14'h3FFF, 1'b1};
        vecs[2] = '{1'b1, 14'h0000, 1'b1, 14'h1555, 1'b0};
        vecs[3] = '{1'b1, 14'h2AAA, 1'b1, 14'h3FFE, 1'b0};
        vecs[4] = '{1'b0, 14'h0000, 1'b1, 14'h1234, 1'b1};
        vecs[5] = '{1'b1, 14'h0F0F, 1'b1, 14'h30F0, 1'b0};
        vecs[6] = '{1'b1, 14'h3FFF, 1'b0, 14'h0000, 1'b0};
        vecs[7] = '{1'b1, 14'h0001, 1'b1, 14'h2000, 1'b1};

        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        in0_valid  = 1'b0;
        in1_valid  = 1'b0;
        in0_data   = '0;
        in1_data   = '0;
        force_ack  = 1'b0;
        auto_ack   = 1'b1;
        ack_delay  = 3;
        ack_hold   = 0;
        model_last = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("rst_in0_ready", {31'd0, in0_ready}, 32'd1);
        checkOutput("rst_in1_ready", {31'd0, in1_ready}, 32'd1);
        checkOutput("rst_out_req", {31'd0, out_req}, 32'd0);
        checkOutput("rst_out_data", {18'd0, out_data}, 32'd0);
        checkOutput("rst_last_grant", {31'd0, last_grant}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single packet: request one cycle after accept, ready returns right after the grant.
        pushExp(14'h2A5, 1'b0);
        in0_valid = 1'b1;
        in0_data  = 14'h2A5;
        @(posedge clk);
        @(negedge clk);
        in0_valid = 1'b0;
        checkOutput("t1_in0_full", {31'd0, in0_ready}, 32'd0);
        checkOutput("t1_req_not_yet", {31'd0, out_req}, 32'd0);
        @(negedge clk);
        checkOutput("t1_req_up", {31'd0, out_req}, 32'd1);
        checkOutput("t1_data", {18'd0, out_data}, 32'h2A5);
        checkOutput("t1_in0_ready_back", {31'd0, in0_ready}, 32'd1);
        waitDrain();

        // Simultaneous arrival right after reset: in0 wins the tie.
        doReset();
        pushExp(14'h0011, 1'b0);
        pushExp(14'h1022, 1'b1);
        applyStimulus(1'b1, 14'h0011, 1'b1, 14'h1022);
        waitDrain();
        checkOutput("t2_last_grant", {31'd0, last_grant}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].v0 && vecs[i].v1) begin
                if (!vecs[i].first) begin
                    pushExp(vecs[i].d0, 1'b0);
                    pushExp(vecs[i].d1, 1'b1);
                end else begin
                    pushExp(vecs[i].d1, 1'b1);
                    pushExp(vecs[i].d0, 1'b0);
                end
            end else if (vecs[i].v0) begin
                pushExp(vecs[i].d0, 1'b0);
            end else begin
                pushExp(vecs[i].d1, 1'b1);
            end
            applyStimulus(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1);
            waitDrain();
        end

        // Both inputs streaming: deliveries alternate starting with the input not served last.
        g = ~model_last;
        for (int i = 0; i < 6; i++) begin
            if (!g) begin
                pushExp(14'h0100 + 14'(i), 1'b0);
                pushExp(14'h2200 + 14'(i), 1'b1);
            end else begin
                pushExp(14'h2200 + 14'(i), 1'b1);
                pushExp(14'h0100 + 14'(i), 1'b0);
            end
            applyStimulus(1'b1, 14'h0100 + 14'(i), 1'b1, 14'h2200 + 14'(i));
        end
        waitDrain();

        // Long ack hold: no new grant while ack stays high, in1 packet stays buffered.
        ack_hold = 20;
        pushExp(14'h0555, 1'b0);
        pushExp(14'h2222, 1'b1);
        applyStimulus(1'b1, 14'h0555, 1'b0, 14'h0000);
        applyStimulus(1'b0, 14'h0000, 1'b1, 14'h2222);
        n = 0;
        while (!(out_ack && !out_req) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t4_hold_reached", {31'd0, (n < 50)}, 32'd1);
        repeat (10) @(negedge clk);
        checkOutput("t4_req_low", {31'd0, out_req}, 32'd0);
        checkOutput("t4_in1_waiting", {31'd0, in1_ready}, 32'd0);
        checkOutput("t4_data_held", {18'd0, out_data}, 32'h0555);
        checkOutput("t4_last_grant", {31'd0, last_grant}, 32'd0);
        waitDrain();
        ack_hold = 0;

        // Reset during an active request with both buffers full.
        auto_ack = 1'b0;
        g = ~model_last;
        applyStimulus(1'b1, 14'h0777, 1'b1, 14'h0888);
        n = 0;
        while (!out_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!g) applyStimulus(1'b1, 14'h0999, 1'b0, 14'h0000);
        else    applyStimulus(1'b0, 14'h0000, 1'b1, 14'h0AAA);
        checkOutput("t5_req_before", {31'd0, out_req}, 32'd1);
        checkOutput("t5_in0_full", {31'd0, in0_ready}, 32'd0);
        checkOutput("t5_in1_full", {31'd0, in1_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_req_drop", {31'd0, out_req}, 32'd0);
        checkOutput("t5_in0_ready", {31'd0, in0_ready}, 32'd1);
        checkOutput("t5_in1_ready", {31'd0, in1_ready}, 32'd1);
        checkOutput("t5_data_clr", {18'd0, out_data}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_last = 1'b1;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (out_req) ok = 1'b0;
        end
        checkOutput("t5_no_spurious", {31'd0, ok}, 32'd1);
        auto_ack = 1'b1;
        pushExp(14'h1357, 1'b1);
        applyStimulus(1'b0, 14'h0000, 1'b1, 14'h1357);
        waitDrain();

        // Ack raised with no request: flagged, no grant until it is withdrawn.
        checkOutput("t6_flag_clear", {31'd0, dut.ack_violation}, 32'd0);
        force_ack = 1'b1;
        repeat (4) @(negedge clk);
        pushExp(14'h0246, 1'b0);
        applyStimulus(1'b1, 14'h0246, 1'b0, 14'h0000);
        ok = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_req) ok = 1'b0;
        end
        checkOutput("t6_no_grant", {31'd0, ok}, 32'd1);
        checkOutput("t6_in0_held", {31'd0, in0_ready}, 32'd0);
        checkOutput("t6_flag_set", {31'd0, dut.ack_violation}, 32'd1);
        force_ack = 1'b0;
        n = 0;
        while (!out_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t6_regrant_latency", {31'd0, (n <= 4)}, 32'd1);
        waitDrain();

        checkOutput("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
